codec_init_sequencer: RTL and testbench

Responder side of the synth's codec-initialisation handshake.
- Starts when the init controller raises INIT.
- Performs a fixed sequence of WM8731 register writes over an I2C master. The I2C master is bit-banged, open-drain and write-only.
- Asserts INIT_FINISH when the sequence completes.
- Sits between the top-level init FSM and the codec's I2C pins. It runs once per INIT request, before the audio datapath is enabled.

---
 rtl/codec_init_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_sequencer.sv
// Codec init sequencer: on INIT, writes the fixed WM8731 register table through a
// write-only, open-drain, bit-banged I2C master, then raises INIT_FINISH.
module codec_init_sequencer #(
  parameter int unsigned CLK_DIV    = 125,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned NUM_WRITES = 11
) (
  input  logic Clk,
  input  logic Reset,
  input  logic INIT,
  output logic INIT_FINISH,
  output logic BUSY,
  output logic ACK_ERR,
  output logic I2C_SCLK,
  output logic I2C_SDAT_OE,
  input  logic I2C_SDAT_IN
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_WRITES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP, S_NEXT, S_DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [1:0]       qtr;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [7:0]       sh;
  logic             nack;
  logic [IDX_W-1:0] idx;

  // Write table entries as {reg[6:0], data[8:0]}
  function automatic logic [15:0] table_entry(input logic [IDX_W-1:0] i);
    case (32'(i))
      32'd0:   table_entry = {7'd15, 9'h000};
      32'd1:   table_entry = {7'd0,  9'h017};
      32'd2:   table_entry = {7'd1,  9'h017};
      32'd3:   table_entry = {7'd2,  9'h079};
      32'd4:   table_entry = {7'd3,  9'h079};
      32'd5:   table_entry = {7'd4,  9'h012};
      32'd6:   table_entry = {7'd5,  9'h000};
      32'd7:   table_entry = {7'd6,  9'h000};
      32'd8:   table_entry = {7'd7,  9'h00A};
      32'd9:   table_entry = {7'd8,  9'h000};
      32'd10:  table_entry = {7'd9,  9'h001};
      default: table_entry = 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] tx_byte(input logic [15:0] e, input logic [1:0] n);
    case (n)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = e[15:8];
      default: tx_byte = e[7:0];
    endcase
  endfunction

  logic [15:0] entry;
  logic [7:0]  cur_byte;
  logic [7:0]  nxt_byte;

  assign entry    = table_entry(idx);
  assign cur_byte = tx_byte(entry, byte_cnt);
  assign nxt_byte = tx_byte(entry, byte_cnt + 2'd1);

  // Sequencer FSM; tick is a registered strobe, one cycle after the divider wraps
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      div         <= '0;
      tick        <= 1'b0;
      qtr         <= 2'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 2'd0;
      sh          <= 8'h00;
      nack        <= 1'b0;
      idx         <= '0;
      INIT_FINISH <= 1'b0;
      BUSY        <= 1'b0;
      ACK_ERR     <= 1'b0;
      I2C_SCLK    <= 1'b1;
      I2C_SDAT_OE <= 1'b0;
    end else begin
      if (state != S_IDLE && state != S_DONE) begin
        div  <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        tick <= (div == DIV_LAST);
      end

      case (state)
        S_IDLE: if (INIT) begin
          state       <= S_START;
          BUSY        <= 1'b1;
          ACK_ERR     <= 1'b0;
          idx         <= '0;
          div         <= '0;
          tick        <= 1'b0;
          qtr         <= 2'd0;
          byte_cnt    <= 2'd0;
          I2C_SCLK    <= 1'b1;
          I2C_SDAT_OE <= 1'b0;
        end

        S_START: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd0: I2C_SDAT_OE <= 1'b1;
            2'd1: I2C_SCLK    <= 1'b0;
            2'd3: begin
              state       <= S_SHIFT;
              bit_cnt     <= 3'd0;
              I2C_SDAT_OE <= ~cur_byte[7];
              sh          <= {cur_byte[6:0], 1'b0};
            end
            default: ;
          endcase
        end

        S_SHIFT: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd0: I2C_SCLK <= 1'b1;
            2'd2: I2C_SCLK <= 1'b0;
            2'd3: begin
              if (bit_cnt == 3'd7) begin
                state       <= S_ACK;
                I2C_SDAT_OE <= 1'b0;
              end else begin
                bit_cnt     <= bit_cnt + 3'd1;
                I2C_SDAT_OE <= ~sh[7];
                sh          <= {sh[6:0], 1'b0};
              end
            end
            default: ;
          endcase
        end

        S_ACK: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd0: I2C_SCLK <= 1'b1;
            2'd2: begin
              I2C_SCLK <= 1'b0;
              nack     <= I2C_SDAT_IN;
            end
            2'd3: begin
              if (nack || byte_cnt == 2'd2) begin
                state       <= S_STOP;
                I2C_SDAT_OE <= 1'b1;
                ACK_ERR     <= ACK_ERR | nack;
              end else begin
                state       <= S_SHIFT;
                byte_cnt    <= byte_cnt + 2'd1;
                bit_cnt     <= 3'd0;
                I2C_SDAT_OE <= ~nxt_byte[7];
                sh          <= {nxt_byte[6:0], 1'b0};
              end
            end
            default: ;
          endcase
        end

        S_STOP: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd0: I2C_SCLK    <= 1'b1;
            2'd1: I2C_SDAT_OE <= 1'b0;
            2'd3: state       <= S_GAP;
            default: ;
          endcase
        end

        S_GAP: if (tick) begin
          qtr <= qtr + 2'd1;
          if (qtr == 2'd3) state <= S_NEXT;
        end

        // Takes one cycle out of the following START's idle first quarter
        S_NEXT: begin
          idx <= idx + IDX_W'(1);
          if (32'(idx) + 32'd1 < NUM_WRITES) begin
            state    <= S_START;
            byte_cnt <= 2'd0;
          end else begin
            state       <= S_DONE;
            BUSY        <= 1'b0;
            INIT_FINISH <= 1'b1;
          end
        end

        S_DONE: if (!INIT) begin
          state       <= S_IDLE;
          INIT_FINISH <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: I2C slave/decoder with protocol checks and a
// cycle-count handshake model, driven by fixed and randomized scenarios.
`timescale 1ns/1ps
module tb_codec_init_sequencer;

  localparam int unsigned CLK_DIV = 2;
  localparam int          NW      = 11;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic INIT = 1'b0;
  logic INIT_FINISH, BUSY, ACK_ERR, I2C_SCLK, I2C_SDAT_OE, I2C_SDAT_IN;
  logic slave_pull = 1'b0;

  assign I2C_SDAT_IN = ~(I2C_SDAT_OE | slave_pull);

  codec_init_sequencer #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A), .NUM_WRITES(NW)) dut (
    .Clk(Clk), .Reset(Reset), .INIT(INIT), .INIT_FINISH(INIT_FINISH), .BUSY(BUSY),
    .ACK_ERR(ACK_ERR), .I2C_SCLK(I2C_SCLK), .I2C_SDAT_OE(I2C_SDAT_OE),
    .I2C_SDAT_IN(I2C_SDAT_IN)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Register table as published for the codec
  int reg_tab  [NW] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int data_tab [NW] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h00A, 'h000, 'h001};

  int nack_entry = -1;
  int nack_byte  = -1;

  // Quarters per transaction, then total INIT->INIT_FINISH latency in cycles
  function automatic int seq_len();
    int q = 0;
    for (int k = 0; k < NW; k++)
      q += (k == nack_entry) ? 12 + 36 * (nack_byte + 1) : 120;
    return 2 + int'(CLK_DIV) * q;
  endfunction

  // ---------------- handshake model ----------------
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t m_ph = M_IDLE;
  int   m_rem = 0;
  bit   m_busy = 0, m_fin = 0, m_aerr = 0;
  int   cyc = 0, start_cyc = 0, seq_starts = 0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Reset) begin
      m_ph <= M_IDLE; m_busy <= 0; m_fin <= 0; m_aerr <= 0;
    end else begin
      case (m_ph)
        M_IDLE: if (INIT) begin
          m_ph <= M_RUN; m_busy <= 1; m_aerr <= 0;
          m_rem <= seq_len() - 1;
          start_cyc <= cyc + 1;
          seq_starts <= seq_starts + 1;
        end
        M_RUN: if (m_rem == 0) begin
          m_ph <= M_DONE; m_busy <= 0; m_fin <= 1; m_aerr <= (nack_entry >= 0);
        end else m_rem <= m_rem - 1;
        M_DONE: if (!INIT) begin
          m_ph <= M_IDLE; m_fin <= 0;
        end
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  // ---------------- bus monitor / slave / decoder ----------------
  logic       p_scl = 1'b1, p_sda = 1'b1, p_fin = 1'b0, mon_sda;
  bit         in_txn = 0, hi_track = 0;
  int         rc = 0, byte_num = 0, dec_count = 0, last_starts = 0, hi_cnt = 0;
  int         lat = -1, fin_hi_cnt = 0;
  logic [7:0] shv = 8'h00;
  logic [7:0] got_bytes [$];
  logic [7:0] eb [3];
  logic [23:0] txn_log [NW];
  int         txn_len [NW];

  always @(negedge Clk) begin
    // Per-cycle comparison against the handshake model
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("init_finish", 32'(INIT_FINISH), 32'(m_fin));
    if (m_ph != M_RUN || nack_entry < 0 || (cyc - start_cyc) < 40)
      chk("ack_err", 32'(ACK_ERR), 32'(m_aerr));
    if (m_ph != M_RUN) begin
      chk("idle_scl", 32'(I2C_SCLK), 32'd1);
      chk("idle_oe", 32'(I2C_SDAT_OE), 32'd0);
    end

    if (last_starts != seq_starts) begin
      last_starts = seq_starts;
      dec_count = 0; lat = -1; fin_hi_cnt = 0;
      for (int i = 0; i < NW; i++) begin txn_log[i] = 24'h0; txn_len[i] = 0; end
    end
    if (INIT_FINISH && !p_fin) lat = cyc - start_cyc;
    if (INIT_FINISH) fin_hi_cnt++;
    p_fin = INIT_FINISH;

    mon_sda = I2C_SDAT_IN;
    if (Reset) begin
      in_txn = 0; rc = 0; slave_pull = 1'b0; hi_track = 0;
      p_scl = 1'b1; p_sda = 1'b1;
    end else begin
      if (p_scl && I2C_SCLK && (p_sda !== mon_sda)) begin
        if (!mon_sda) begin
          chk("start_while_idle", 32'(in_txn), 32'd0);
          in_txn = 1; rc = 0; byte_num = 0; hi_track = 0;
          got_bytes.delete();
        end else begin
          chk("stop_at_boundary", 32'(in_txn && rc == 1), 32'd1);
          if (dec_count < NW) begin
            eb[0] = 8'h34;
            eb[1] = 8'({reg_tab[dec_count][6:0], data_tab[dec_count][8]});
            eb[2] = 8'(data_tab[dec_count][7:0]);
            chk("txn_len", 32'(got_bytes.size()),
                32'((dec_count == nack_entry) ? nack_byte + 1 : 3));
            txn_log[dec_count] = 24'h0;
            for (int i = 0; i < got_bytes.size() && i < 3; i++) begin
              chk("txn_byte", 32'(got_bytes[i]), 32'(eb[i]));
              txn_log[dec_count][23 - 8*i -: 8] = got_bytes[i];
            end
            txn_len[dec_count] = got_bytes.size();
          end else chk("extra_write", 32'(dec_count), 32'(NW - 1));
          dec_count++;
          in_txn = 0; hi_track = 0;
        end
      end else if (!p_scl && I2C_SCLK && in_txn) begin
        rc++;
        if (rc <= 8) shv = {shv[6:0], mon_sda};
        hi_track = 1; hi_cnt = 0;
      end else if (p_scl && !I2C_SCLK && in_txn) begin
        if (hi_track) chk("scl_high_cycles", 32'(hi_cnt), 32'(2 * CLK_DIV));
        hi_track = 0;
        if (rc == 8) slave_pull = !(dec_count == nack_entry && byte_num == nack_byte);
        else if (rc == 9) begin
          slave_pull = 1'b0;
          got_bytes.push_back(shv);
          byte_num++; rc = 0;
        end
      end
      if (hi_track && I2C_SCLK) hi_cnt++;
      p_scl = I2C_SCLK;
      p_sda = mon_sda;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (m_ph != M_DONE && k < budget) begin step(1); k++; end
    chk({name, "_reached_done"}, 32'(m_ph == M_DONE), 32'd1);
    @(negedge Clk); #1;
    chk({name, "_writes_seen"}, 32'(dec_count), 32'(NW));
    chk({name, "_latency"}, 32'(lat), 32'(seq_len()));
  endtask

  initial begin
    int drop;
    Reset = 1'b1; INIT = 1'b0;
    step(3);
    Reset = 1'b0;
    step(2);
    chk("reset_scl", 32'(I2C_SCLK), 32'd1);
    chk("reset_oe", 32'(I2C_SDAT_OE), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_fin", 32'(INIT_FINISH), 32'd0);

    // Full sequence, every byte ACKed
    INIT = 1'b1;
    wait_done("full", 3000);
    chk("full_latency_literal", 32'(lat), 32'd2642);
    chk("first_write", 32'(txn_log[0]), 32'h341E00);
    chk("last_write", 32'(txn_log[10]), 32'h341201);
    chk("full_ack_err", 32'(ACK_ERR), 32'd0);
    step(5);
    chk("fin_held", 32'(INIT_FINISH), 32'd1);
    INIT = 1'b0;
    step(1);
    chk("fin_dropped", 32'(INIT_FINISH), 32'd0);
    step(3);

    // NACK on byte1 of R2
    nack_entry = 3; nack_byte = 1;
    INIT = 1'b1;
    wait_done("nack", 3000);
    chk("nack_latency_literal", 32'(lat), 32'd2570);
    chk("nack_ack_err", 32'(ACK_ERR), 32'd1);
    chk("nack_txn_len", 32'(txn_len[3]), 32'd2);
    chk("nack_txn_bytes", 32'(txn_log[3]), 32'h340400);
    chk("after_nack_r3", 32'(txn_log[4]), 32'h340679);
    INIT = 1'b0;
    step(3);
    nack_entry = -1; nack_byte = -1;
    INIT = 1'b1;
    step(2);
    chk("ack_err_cleared", 32'(ACK_ERR), 32'd0);
    wait_done("second", 3000);
    INIT = 1'b0;
    step(3);

    // INIT dropped mid-sequence
    INIT = 1'b1;
    step(500);
    INIT = 1'b0;
    wait_done("drop", 3000);
    step(3);
    chk("fin_pulse_cycles", 32'(fin_hi_cnt), 32'd1);
    chk("drop_idle_busy", 32'(BUSY), 32'd0);

    // Reset mid-transaction
    INIT = 1'b1;
    step(700);
    Reset = 1'b1;
    step(1);
    chk("abort_scl", 32'(I2C_SCLK), 32'd1);
    chk("abort_oe", 32'(I2C_SDAT_OE), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_fin", 32'(INIT_FINISH), 32'd0);
    Reset = 1'b0; INIT = 1'b0;
    step(5);
    INIT = 1'b1;
    wait_done("restart", 3000);
    chk("restart_first_write", 32'(txn_log[0]), 32'h341E00);
    INIT = 1'b0;
    step(3);

    // Randomized rounds: NACK placement and INIT release time
    for (int r = 0; r < 4; r++) begin
      nack_entry = int'($urandom_range(0, 13));
      if (nack_entry >= NW) nack_entry = -1;
      nack_byte = (nack_entry >= 0) ? int'($urandom_range(0, 2)) : -1;
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 2000)) : 0;
      INIT = 1'b1;
      if (drop > 0) begin
        step(drop);
        INIT = 1'b0;
      end
      wait_done("random", 3000);
      chk("random_ack_err", 32'(ACK_ERR), 32'(nack_entry >= 0));
      step(int'($urandom_range(1, 6)));
      INIT = 1'b0;
      step(int'($urandom_range(2, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
